serial_subtractor: RTL and testbench



---
 rtl/serial_subtractor.sv | 161 ++++++++++++++++
 tb/tb_serial_subtractor.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// serial_subtractor
// -----------------------------------------------------------------------------
// Computes diff = (A - B) mod 2^64, eight bits per clock, least significant
// slice first. A registered borrow carries between slices. The critical path
// is therefore one 8-bit subtract instead of a 64-bit borrow chain.
//
// Handshake:
//   - An accepted start (in IDLE or DONE) latches A and B.
//   - busy is high for the 8 slice cycles.
//   - done pulses for one cycle when diff becomes valid.
//   - diff holds its value until the next completion.
//
// Ports:
//   clk         in   1   rising-edge clock
//   rst_n       in   1   asynchronous active-low reset
//   start       in   1   operation request, ignored while busy
//   A           in   64  minuend, sampled on an accepted start
//   B           in   64  subtrahend, sampled on an accepted start
//   busy        out  1   subtraction in progress
//   done        out  1   one-cycle completion pulse
//   diff        out  64  registered result
//   borrow_out  out  1   final borrow (A < B unsigned);
//                        present only when SUB_BORROW_OUT_EN is defined
//
// Configuration macro: SUB_BORROW_OUT_EN
//   - Defined: adds the registered borrow_out port.
//   - Undefined: the final borrow is discarded.
// -----------------------------------------------------------------------------
module serial_subtractor (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [63:0] A,
  input  logic [63:0] B,
  output logic        busy,
  output logic        done,
  output logic [63:0] diff
`ifdef SUB_BORROW_OUT_EN
  ,
  output logic        borrow_out
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [63:0] a_q, a_d;
  logic [63:0] b_q, b_d;
  logic [63:0] work_q, work_d;
  logic [63:0] diff_q, diff_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        borrow_q, borrow_d;
  logic [8:0]  slice_diff;
  logic [5:0]  slice_base;

`ifdef SUB_BORROW_OUT_EN
  logic        borrow_out_q, borrow_out_d;
`endif

  // Bit offset of the slice currently being processed.
  assign slice_base = {cnt_q, 3'b000};

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      work_q   <= '0;
      diff_q   <= '0;
      cnt_q    <= '0;
      borrow_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      work_q   <= work_d;
      diff_q   <= diff_d;
      cnt_q    <= cnt_d;
      borrow_q <= borrow_d;
    end
  end

`ifdef SUB_BORROW_OUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      borrow_out_q <= 1'b0;
    end else begin
      borrow_out_q <= borrow_out_d;
    end
  end
`endif

  // Next-state logic and slice datapath.
  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    work_d     = work_q;
    diff_d     = diff_q;
    cnt_d      = cnt_q;
    borrow_d   = borrow_q;
    slice_diff = 9'd0;
`ifdef SUB_BORROW_OUT_EN
    borrow_out_d = borrow_out_q;
`endif

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          a_d      = A;
          b_d      = B;
          work_d   = '0;
          cnt_d    = 3'd0;
          borrow_d = 1'b0;
          state_d  = ST_RUN;
        end else if (state_q == ST_DONE) begin
          state_d = ST_IDLE;
        end
      end

      ST_RUN: begin
        // Subtract in 9 bits. Bit 8 is set exactly when the slice underflows,
        // which is the borrow into the next slice.
        slice_diff = {1'b0, a_q[slice_base +: 8]}
                   - {1'b0, b_q[slice_base +: 8]}
                   - {8'd0, borrow_q};
        work_d[slice_base +: 8] = slice_diff[7:0];
        borrow_d = slice_diff[8];

        if (cnt_q == 3'd7) begin
          // The last slice goes straight into the result so that diff
          // updates on the same edge that raises done.
          diff_d  = work_d;
`ifdef SUB_BORROW_OUT_EN
          borrow_out_d = slice_diff[8];
`endif
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign busy = (state_q == ST_RUN);
  assign done = (state_q == ST_DONE);
  assign diff = diff_q;
`ifdef SUB_BORROW_OUT_EN
  assign borrow_out = borrow_out_q;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor
// -----------------------------------------------------------------------------
// Directed bench for serial_subtractor.
//   - Inputs are driven and outputs sampled on the falling clock edge, half a
//     cycle away from the active rising edge.
//   - Expected results are hand-computed constants.
//   - model_diff tracks the result the DUT should be holding, so the bench can
//     check that diff stays stable while an operation runs.
// -----------------------------------------------------------------------------
module tb_serial_subtractor;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic [63:0] a = '0;
  logic [63:0] b = '0;
  logic        busy;
  logic        done;
  logic [63:0] diff;
`ifdef SUB_BORROW_OUT_EN
  logic        borrow_out;
`endif

  int          n_cmp = 0;
  int          n_err = 0;
  logic [63:0] model_diff = '0;

  always #5 clk = ~clk;

  serial_subtractor dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .A     (a),
    .B     (b),
    .busy  (busy),
    .done  (done),
    .diff  (diff)
`ifdef SUB_BORROW_OUT_EN
    ,
    .borrow_out (borrow_out)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%h expected=0x%h", tag, obs, exp);
    end
  endtask

  // Run one operation and check its handshake and result.
  //   - Must be called on a falling edge.
  //   - When glitch is set, a stray start with different operands is pulsed
  //     mid-RUN; the DUT must ignore it.
  task automatic run_op(input string tag, input logic [63:0] a_in, input logic [63:0] b_in,
                        input logic [63:0] exp_d, input logic exp_b, input bit glitch);
    int n;
    bit stable;
    a = a_in;
    b = b_in;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    // Operands may change freely after the accepting edge.
    a = ~a_in;
    b = ~b_in;
    n = 0;
    stable = 1'b1;
    while (busy === 1'b1 && n < 20) begin
      if (diff !== model_diff || done !== 1'b0) stable = 1'b0;
      if (glitch && n == 3) begin
        start = 1'b1;
        a = 64'h1;
        b = 64'h0;
      end else begin
        start = 1'b0;
      end
      n++;
      @(negedge clk);
    end
    start = 1'b0;
    chk({tag, "_busy_cycles"}, 64'(n), 64'd8);
    chk({tag, "_diff_stable_while_busy"}, {63'd0, stable}, 64'd1);
    chk({tag, "_done"}, {63'd0, done}, 64'd1);
    chk({tag, "_diff"}, diff, exp_d);
`ifdef SUB_BORROW_OUT_EN
    chk({tag, "_borrow_out"}, {63'd0, borrow_out}, {63'd0, exp_b});
`endif
    $display("op %s: A=0x%h B=0x%h diff=0x%h expected diff=0x%h borrow=%0b",
             tag, a_in, b_in, diff, exp_d, exp_b);
    model_diff = exp_d;
    @(negedge clk);
    chk({tag, "_done_one_cycle"}, {63'd0, done}, 64'd0);
    chk({tag, "_idle_after"}, {63'd0, busy}, 64'd0);
  endtask

  initial begin
    int n;
    bit stable;
    int seen;

    // Reset state.
    #2 rst_n = 1'b0;
    #1;
    chk("reset_busy", {63'd0, busy}, 64'd0);
    chk("reset_done", {63'd0, done}, 64'd0);
    chk("reset_diff", diff, 64'd0);
`ifdef SUB_BORROW_OUT_EN
    chk("reset_borrow_out", {63'd0, borrow_out}, 64'd0);
`endif
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed operations.
    run_op("5_minus_3", 64'd5, 64'd3, 64'h2, 1'b0, 1'b0);
    run_op("0_minus_1", 64'd0, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0);
    run_op("borrow_slice012", 64'h0000_0000_0001_0000, 64'h1, 64'h0000_0000_0000_FFFF, 1'b0, 1'b0);
    run_op("equal_with_glitch", 64'hDEAD_BEEF_CAFE_F00D, 64'hDEAD_BEEF_CAFE_F00D, 64'h0, 1'b0, 1'b1);

    // Back-to-back: 10-4, then start held during its done cycle with 0x100-1.
    a = 64'd10;
    b = 64'd4;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 1;
    while (done !== 1'b1 && n < 20) begin
      n++;
      @(negedge clk);
    end
    chk("b2b_first_latency", 64'(n), 64'd9);
    chk("b2b_first_diff", diff, 64'h6);
    $display("op b2b_first: A=0x%h B=0x%h diff=0x%h expected diff=0x6", 64'd10, 64'd4, diff);
    a = 64'h100;
    b = 64'h1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("b2b_second_accepted", {63'd0, busy}, 64'd1);
    n = 1;
    stable = 1'b1;
    while (done !== 1'b1 && n < 30) begin
      if (diff !== 64'h6) stable = 1'b0;
      n++;
      @(negedge clk);
    end
    chk("b2b_done_spacing", 64'(n), 64'd9);
    chk("b2b_diff_held", {63'd0, stable}, 64'd1);
    chk("b2b_second_diff", diff, 64'hFF);
    $display("op b2b_second: A=0x%h B=0x%h diff=0x%h expected diff=0xff", 64'h100, 64'h1, diff);
    model_diff = 64'hFF;
    @(negedge clk);

    // Reset asserted while slice 4 is in progress.
    a = 64'h1234_5678_9ABC_DEF0;
    b = 64'h1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    chk("abort_busy_before_reset", {63'd0, busy}, 64'd1);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", {63'd0, busy}, 64'd0);
    chk("abort_done", {63'd0, done}, 64'd0);
    chk("abort_diff", diff, 64'd0);
`ifdef SUB_BORROW_OUT_EN
    chk("abort_borrow_out", {63'd0, borrow_out}, 64'd0);
`endif
    $display("op abort: reset at slice 4 busy=%0b done=%0b diff=0x%h", busy, done, diff);
    model_diff = 64'h0;
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (15) begin
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b0) seen++;
    end
    chk("abort_no_spurious_done", 64'(seen), 64'd0);

    // Recovery after the abort.
    run_op("after_abort", 64'h123, 64'h23, 64'h100, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
